// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier with signed/unsigned mode and start/done handshake
module seq_multiplier #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product_out,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t             state;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mag_a;
    logic [CW-1:0]      cnt;
    logic               negate;

    logic               use_signed;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     upper_sum;

    // The magnitude of the most negative value still fits as an unsigned WIDTH-bit number.
    assign use_signed = (SIGNED_EN != 0) && signed_mode;
    assign abs_a      = (use_signed && multiplicand[WIDTH-1])  ? (~multiplicand + 1'b1)  : multiplicand;
    assign abs_b      = (use_signed && multiplier_in[WIDTH-1]) ? (~multiplier_in + 1'b1) : multiplier_in;
    assign upper_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};

    assign busy = (state == CALC) || (state == SIGN);
    assign hi   = product_out[2*WIDTH-1:WIDTH];
    assign lo   = product_out[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            mag_a       <= '0;
            cnt         <= '0;
            negate      <= 1'b0;
            done        <= 1'b0;
            product_out <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mag_a  <= abs_a;
                        acc    <= {{(WIDTH + 1){1'b0}}, abs_b};
                        negate <= use_signed && (multiplicand[WIDTH-1] ^ multiplier_in[WIDTH-1]);
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    // Carry-out of the upper add becomes the new top bit before shifting.
                    if (acc[0]) begin
                        acc <= {upper_sum, acc[WIDTH-1:0]} >> 1;
                    end else begin
                        acc <= acc >> 1;
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= SIGN;
                    end
                end
                SIGN: begin
                    product_out <= negate ? (~acc[2*WIDTH-1:0] + 1'b1) : acc[2*WIDTH-1:0];
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised iterative shift-add multiplier. Generalises the fixed 32-bit unsigned product register.
- Adds a WIDTH parameter, a signed/unsigned mode, a start/busy/done handshake and a held result register.
- Sits beside the ALU as the multi-cycle MULT/MULTU unit.
- Internal adder and control are self-contained; no external ALU is needed.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH. Legal range is 4 or more.
- SIGNED_EN, 1, 1 means the signed_mode input is honoured; 0 means signed_mode is ignored and the unit is unsigned only.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  1 means operands are two's complement; captured with start.
- multiplicand  input  WIDTH  operand A; captured with start.
- multiplier_in  input  WIDTH  operand B; captured with start.
- busy  output  1  high while an operation is in flight (CALC or SIGN).
- done  output  1  single-cycle pulse marking a new product_out.
- product_out  output  2*WIDTH  last completed product; held until the next done.
- hi  output  WIDTH  product_out[2*WIDTH-1:WIDTH].
- lo  output  WIDTH  product_out[WIDTH-1:0].

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, busy 0, done 0, product_out 0, accumulator 0, counter 0, negate flag 0.
- rst has priority over every other input, including start on the same edge.
- rst mid-operation aborts the operation. Nothing partial is ever written to product_out.
- States are IDLE, CALC and SIGN.
- busy = (state == CALC) or (state == SIGN), decoded combinationally from state.
- IDLE, with start = 1 at edge E:
  - Magnitudes: mA = |multiplicand|, mB = |multiplier_in| when signed_mode and SIGNED_EN are both 1; otherwise the raw operands.
  - Negate flag = sign(A) XOR sign(B) in signed mode; otherwise 0.
  - Accumulator (2*WIDTH+1 bits including the carry) = {0, WIDTH zeros, mB}.
  - Latch mA. Counter = 0. Go to CALC.
- IDLE with start = 0: hold.
- CALC, one iteration per edge:
  - If accumulator lsb is 1: acc = {carry, upper WIDTH + mA, lower WIDTH} >> 1. The WIDTH-bit add keeps its carry-out as the new top bit before the shift.
  - Otherwise: acc = acc >> 1.
  - Counter increments each edge. After WIDTH iterations (the edge E+WIDTH) go to SIGN.
- SIGN, at edge E+WIDTH+1:
  - product_out = negate ? (~acc[2W-1:0] + 1) : acc[2W-1:0].
  - done = 1. Go to IDLE.
- done deasserts on the next edge. Pulse width is exactly one cycle.
- Latency: start accepted at edge E gives done high for the cycle after edge E+WIDTH+1.
- Throughput: start may be asserted during the done cycle and is accepted. Back-to-back period is WIDTH+2 cycles.
- start while busy is ignored. It is neither queued nor allowed to disturb the operands in flight.
- Operand inputs may change freely after the accepting edge.
- Width rules:
  - |-2^(W-1)| = 2^(W-1) fits in WIDTH bits unsigned, so no overflow on magnitude.
  - The full 2*WIDTH result is always exact and there is no overflow flag.
  - (-2^(W-1))^2 = 2^(2W-2) is representable.
- A zero operand still takes the full WIDTH+2 cycles; there is no early termination.
- product_out changes only on the done edge or on reset.

Test Plan:
All cases use WIDTH=32 unless stated.
1. Unsigned: start, signed_mode=0, A=0xFFFFFFFF, B=0xFFFFFFFF at edge E -> busy high for 33 cycles; done pulses once after edge E+33; product_out=0xFFFFFFFE_00000001, hi=0xFFFFFFFE, lo=0x00000001.
2. Signed: A=-3 (0xFFFFFFFD), B=7 -> product_out=0xFFFFFFFF_FFFFFFEB. Repeat with signed_mode=0 -> 0x00000006_FFFFFFEB.
3. Signed corner: A=B=0x80000000 -> 0x40000000_00000000. With SIGNED_EN=0 and signed_mode=1 -> 0x40000000_00000000 (unsigned result, same bits). Also A=0x80000000, B=0x00000001 signed -> 0xFFFFFFFF_80000000.
4. Handshake: pulse start with A=5, B=6; re-assert start with A=9, B=9 at cycles 3 and 20 -> both ignored; product_out=30. Then start A=2, B=3 in the done cycle -> accepted; next done gives 6, exactly 34 cycles after the first done.
5. Reset mid-operation: start A=0x1234, B=0x10; assert rst at cycle 10 together with start -> next cycle busy=0, done=0, product_out=0, state IDLE. Fresh start A=7, B=8 -> 56 with nominal latency.
6. WIDTH=8 build: A=0xFF, B=0xFF unsigned -> 0xFE01 after 10 cycles. Signed A=0x80, B=0x7F -> 0xC080. Zero operand -> 0x0000, still 10 cycles.
